// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, instruction field positions,
// datapath widths and small helpers for splitting an instruction word.
package mips_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int IADDR_W  = 4;
    localparam int REG_AW   = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;
    localparam int JTGT_LSB   = 0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } instr_fields_t;

    // Pull every decode field out of a raw instruction word.
    function automatic instr_fields_t split_fields(input logic [DATA_W-1:0] word);
        instr_fields_t f;
        f.opcode = word[OPCODE_LSB +: 6];
        f.rs     = word[RS_LSB +: 5];
        f.rt     = word[RT_LSB +: 5];
        f.rd     = word[RD_LSB +: 5];
        f.shamt  = word[SHAMT_LSB +: 5];
        f.funct  = word[FUNCT_LSB +: 6];
        f.imm    = word[IMM_LSB +: 16];
        return f;
    endfunction

    // Widen a 16-bit immediate to the datapath width, keeping its sign.
    function automatic logic [DATA_W-1:0] sign_extend16(input logic [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Bus between fetch/writeback and the decode stage. The master side
// supplies the fetched word and writeback traffic; the slave side (decode)
// returns the ID/EX bundle and the fetch redirect.
interface instruction_decode_if;
    import mips_pkg::*;

    logic [DATA_W-1:0]  instruction;
    logic [IADDR_W-1:0] pc_in;
    logic               flush;
    logic               wb_we;
    logic [REG_AW-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;

    logic               mux_ctrl;
    logic [IADDR_W-1:0] jp_address;
    logic               id_valid;
    logic [IADDR_W-1:0] id_pc;
    logic [5:0]         id_opcode;
    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic [4:0]         id_rd;
    logic [4:0]         id_shamt;
    logic [5:0]         id_funct;
    logic [DATA_W-1:0]  id_imm;
    logic [DATA_W-1:0]  id_rs_data;
    logic [DATA_W-1:0]  id_rt_data;

    modport master (
        output instruction, pc_in, flush, wb_we, wb_addr, wb_data,
        input  mux_ctrl, jp_address, id_valid, id_pc, id_opcode, id_rs, id_rt,
               id_rd, id_shamt, id_funct, id_imm, id_rs_data, id_rt_data
    );

    modport slave (
        input  instruction, pc_in, flush, wb_we, wb_addr, wb_data,
        output mux_ctrl, jp_address, id_valid, id_pc, id_opcode, id_rs, id_rt,
               id_rd, id_shamt, id_funct, id_imm, id_rs_data, id_rt_data
    );

endinterface

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, register 0 hardwired to zero, whole array cleared by reset.
module register_file
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Write port; register 0 is never stored so it always reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports, with register 0 forced to zero regardless of storage.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != '0) rdata_a = regs[raddr_a];
        if (raddr_b != '0) rdata_b = regs[raddr_b];
    end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: splits the fetched word into the registered ID/EX bundle,
// reads the register file with writeback bypass, issues one-cycle fetch
// redirects for J-type jumps and squashes wrong-path words afterwards.
module instruction_decode
    import mips_pkg::*;
#(
    parameter int         SQUASH_SLOTS = 1,
    parameter logic [5:0] J_OPCODE     = OP_J
) (
    input logic                 clk,
    input logic                 reset,
    instruction_decode_if.slave id_bus
);

    localparam logic [1:0] SQUASH_LOAD = 2'(SQUASH_SLOTS);

    instr_fields_t      fields;
    logic [1:0]         squash_cnt;
    logic               live;
    logic               jump_issue;
    logic [DATA_W-1:0]  rf_rs_data;
    logic [DATA_W-1:0]  rf_rt_data;
    logic [DATA_W-1:0]  rs_fwd;
    logic [DATA_W-1:0]  rt_fwd;

    logic               mux_ctrl_q;
    logic [IADDR_W-1:0] jp_address_q;
    logic               id_valid_q;
    logic [IADDR_W-1:0] id_pc_q;
    instr_fields_t      id_fields_q;
    logic [DATA_W-1:0]  id_rs_data_q;
    logic [DATA_W-1:0]  id_rt_data_q;

    assign fields     = split_fields(id_bus.instruction);
    assign live       = (squash_cnt == 2'd0) && !id_bus.flush;
    assign jump_issue = live && (fields.opcode == J_OPCODE);

    register_file u_register_file (
        .clk     (clk),
        .rst_n   (reset),
        .we      (id_bus.wb_we),
        .waddr   (id_bus.wb_addr),
        .wdata   (id_bus.wb_data),
        .raddr_a (fields.rs),
        .raddr_b (fields.rt),
        .rdata_a (rf_rs_data),
        .rdata_b (rf_rt_data)
    );

    // Same-cycle writeback wins over the stored value, except for register 0.
    always_comb begin
        rs_fwd = rf_rs_data;
        rt_fwd = rf_rt_data;
        if (id_bus.wb_we && (id_bus.wb_addr == fields.rs) && (fields.rs != '0))
            rs_fwd = id_bus.wb_data;
        if (id_bus.wb_we && (id_bus.wb_addr == fields.rt) && (fields.rt != '0))
            rt_fwd = id_bus.wb_data;
    end

    // Squash counter: reloads on a redirect or flush, otherwise drains to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            squash_cnt <= SQUASH_LOAD;
        end else if (jump_issue || id_bus.flush) begin
            squash_cnt <= SQUASH_LOAD;
        end else if (squash_cnt != 2'd0) begin
            squash_cnt <= squash_cnt - 2'd1;
        end
    end

    // ID/EX register: fields captured every edge, valid marks live words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_fields_q  <= '0;
            id_rs_data_q <= '0;
            id_rt_data_q <= '0;
        end else begin
            id_valid_q   <= live;
            id_pc_q      <= id_bus.pc_in;
            id_fields_q  <= fields;
            id_rs_data_q <= rs_fwd;
            id_rt_data_q <= rt_fwd;
        end
    end

    // Fetch redirect: one-cycle mux_ctrl pulse, target held until next jump.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mux_ctrl_q   <= 1'b0;
            jp_address_q <= '0;
        end else begin
            mux_ctrl_q <= jump_issue;
            if (jump_issue)
                jp_address_q <= id_bus.instruction[JTGT_LSB +: IADDR_W];
        end
    end

    assign id_bus.mux_ctrl   = mux_ctrl_q;
    assign id_bus.jp_address = jp_address_q;
    assign id_bus.id_valid   = id_valid_q;
    assign id_bus.id_pc      = id_pc_q;
    assign id_bus.id_opcode  = id_fields_q.opcode;
    assign id_bus.id_rs      = id_fields_q.rs;
    assign id_bus.id_rt      = id_fields_q.rt;
    assign id_bus.id_rd      = id_fields_q.rd;
    assign id_bus.id_shamt   = id_fields_q.shamt;
    assign id_bus.id_funct   = id_fields_q.funct;
    assign id_bus.id_imm     = sign_extend16(id_fields_q.imm);
    assign id_bus.id_rs_data = id_rs_data_q;
    assign id_bus.id_rt_data = id_rt_data_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Testbench for instruction_decode: directed vectors with literal
// expectations, plus a behavioural model compared on every falling edge.
module tb_instruction_decode;

    localparam int         SLOTS = 1;
    localparam logic [5:0] J_OP  = 6'h02;

    logic clk;
    logic reset;
    bit   cmp_en;
    int   passed;
    int   total;

    instruction_decode_if bus ();

    instruction_decode #(
        .SQUASH_SLOTS (SLOTS),
        .J_OPCODE     (J_OP)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .id_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check counts here.
    task automatic check_output(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state: what the ID/EX outputs must be after each edge.
    int          m_squash;
    logic [31:0] m_regs [32];
    logic [31:0] m_word;
    logic [3:0]  m_pc;
    logic [3:0]  m_jp;
    bit          m_valid;
    bit          m_mux;
    logic [31:0] m_rs;
    logic [31:0] m_rt;
    bit          m_live;
    bit          m_jump;

    // A register read sees a same-cycle write, but register 0 is always zero.
    function automatic logic [31:0] model_read(input int idx);
        if (idx == 0) return 32'd0;
        if (bus.wb_we && (int'(bus.wb_addr) == idx)) return bus.wb_data;
        return m_regs[idx];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_squash = SLOTS;
            m_word = 32'd0; m_pc = 4'd0; m_jp = 4'd0;
            m_valid = 0; m_mux = 0; m_rs = 32'd0; m_rt = 32'd0;
        end else begin
            m_live = (m_squash == 0) && !bus.flush;
            m_jump = m_live && ((bus.instruction >> 26) == 32'(J_OP));
            m_rs = model_read(int'((bus.instruction >> 21) & 32'h1f));
            m_rt = model_read(int'((bus.instruction >> 16) & 32'h1f));
            if (bus.wb_we && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] = bus.wb_data;
            m_word  = bus.instruction;
            m_pc    = bus.pc_in;
            m_valid = m_live;
            m_mux   = m_jump;
            if (m_jump) m_jp = bus.instruction[3:0];
            if (m_jump || bus.flush) m_squash = SLOTS;
            else if (m_squash > 0) m_squash = m_squash - 1;
        end
    end

    // Compare the whole bundle against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("ctrl", {bus.id_valid, bus.mux_ctrl, bus.jp_address},
                         {m_valid, m_mux, m_jp});
            check_output("fields",
                {bus.id_pc, bus.id_opcode, bus.id_rs, bus.id_rt, bus.id_rd,
                 bus.id_shamt, bus.id_funct, bus.id_imm},
                {m_pc, m_word[31:26], m_word[25:21], m_word[20:16], m_word[15:11],
                 m_word[10:6], m_word[5:0], 32'(signed'(m_word[15:0]))});
            check_output("rs_data", bus.id_rs_data, m_rs);
            check_output("rt_data", bus.id_rt_data, m_rt);
        end
    end

    // Present one word plus writeback traffic and wait until it is in ID/EX.
    task automatic apply_stimulus(input logic [31:0] instr, input logic [3:0] pc,
                                  input logic fl, input logic we,
                                  input logic [4:0] wa, input logic [31:0] wd);
        bus.instruction = instr;
        bus.pc_in       = pc;
        bus.flush       = fl;
        bus.wb_we       = we;
        bus.wb_addr     = wa;
        bus.wb_data     = wd;
        @(negedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        cmp_en = 0;
        reset  = 1'b0;
        bus.instruction = 32'h0000_0020;
        bus.pc_in = 4'd0; bus.flush = 1'b0;
        bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
        #6;
        cmp_en = 1;
        check_output("reset_valid", bus.id_valid, 1'b0);
        check_output("reset_mux", {bus.mux_ctrl, bus.jp_address}, 5'd0);
        check_output("reset_funct", bus.id_funct, 6'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        apply_stimulus(32'h0000_0020, 4'd0, 0, 0, 5'd0, 32'd0);
        check_output("first_word_squashed", {bus.id_valid, bus.mux_ctrl}, 2'b00);
        apply_stimulus(32'h0000_0020, 4'd1, 0, 0, 5'd0, 32'd0);
        check_output("second_word_valid", {bus.id_valid, bus.mux_ctrl}, 2'b10);
        check_output("second_word_funct", bus.id_funct, 6'h20);

        apply_stimulus(32'h0123_4567, 4'd2, 0, 0, 5'd0, 32'd0);
        check_output("field_split",
            {bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_funct, bus.id_imm},
            {5'd9, 5'd3, 5'd8, 5'd21, 6'h27, 32'h0000_4567});

        apply_stimulus(32'h0800_0007, 4'd3, 0, 0, 5'd0, 32'd0);
        check_output("jump_redirect", {bus.id_valid, bus.mux_ctrl, bus.jp_address, bus.id_pc},
                     {1'b1, 1'b1, 4'h7, 4'd3});
        apply_stimulus(32'h0000_0020, 4'd4, 0, 0, 5'd0, 32'd0);
        check_output("wrong_path_dropped", {bus.id_valid, bus.mux_ctrl, bus.jp_address},
                     {1'b0, 1'b0, 4'h7});
        apply_stimulus(32'h0000_0020, 4'd7, 0, 0, 5'd0, 32'd0);
        check_output("target_valid", bus.id_valid, 1'b1);

        apply_stimulus(32'h0000_0020, 4'd8, 0, 1, 5'd5, 32'hDEAD_BEEF);
        apply_stimulus(32'h00A0_0020, 4'd9, 0, 0, 5'd0, 32'd0);
        check_output("rf_read_after_write", bus.id_rs_data, 32'hDEAD_BEEF);
        apply_stimulus(32'h00A0_0020, 4'd10, 0, 1, 5'd5, 32'h1234_5678);
        check_output("rs_bypass", bus.id_rs_data, 32'h1234_5678);
        apply_stimulus(32'h0005_0020, 4'd11, 0, 1, 5'd5, 32'hCAFE_F00D);
        check_output("rt_bypass", bus.id_rt_data, 32'hCAFE_F00D);

        apply_stimulus(32'h0000_0020, 4'd12, 0, 1, 5'd0, 32'hFFFF_FFFF);
        check_output("r0_same_cycle", bus.id_rs_data, 32'd0);
        apply_stimulus(32'h0000_0020, 4'd13, 0, 0, 5'd0, 32'd0);
        check_output("r0_after_write", bus.id_rs_data, 32'd0);

        apply_stimulus(32'h0800_0009, 4'd14, 1, 0, 5'd0, 32'd0);
        check_output("flush_beats_jump", {bus.id_valid, bus.mux_ctrl, bus.jp_address},
                     {1'b0, 1'b0, 4'h7});
        apply_stimulus(32'h0000_0020, 4'd15, 0, 0, 5'd0, 32'd0);
        check_output("flush_squash", bus.id_valid, 1'b0);
        apply_stimulus(32'h0000_0020, 4'd0, 0, 0, 5'd0, 32'd0);
        check_output("after_flush_valid", bus.id_valid, 1'b1);

        apply_stimulus(32'h2000_8001, 4'd1, 0, 0, 5'd0, 32'd0);
        check_output("imm_sign_ext", {bus.id_valid, bus.id_imm}, {1'b1, 32'hFFFF_8001});
        apply_stimulus(32'h0800_0003, 4'd2, 0, 0, 5'd0, 32'd0);
        check_output("jump_before_reset", {bus.mux_ctrl, bus.jp_address}, {1'b1, 4'h3});
        reset = 1'b0;
        #1;
        check_output("async_reset_ctrl", {bus.id_valid, bus.mux_ctrl, bus.jp_address}, 6'd0);
        check_output("async_reset_data", {bus.id_imm, bus.id_rs_data, bus.id_pc}, 68'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        apply_stimulus(32'h0000_0020, 4'd3, 0, 0, 5'd0, 32'd0);
        check_output("post_reset_squash", bus.id_valid, 1'b0);
        apply_stimulus(32'h00A0_0020, 4'd4, 0, 0, 5'd0, 32'd0);
        check_output("post_reset_regs_clear", {bus.id_valid, bus.id_rs_data}, {1'b1, 32'd0});

        cmp_en = 0;
        #1;
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
